// File: rtl/fmac_wb_frontend_if.sv
// Signal bundle for the F-MAC front end: Wishbone-classic slave port plus the
// operand/result link to the MAC datapath. "slave" is the front end's view.
interface fmac_wb_frontend_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
);
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i;
    logic [31:0]       wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;

    logic              mac_valid_o;
    logic              mac_ready_i;
    logic [DATA_W-1:0] mac_a_o;
    logic [DATA_W-1:0] mac_b_o;
    logic              mac_clr_o;
    logic              mac_res_valid_i;
    logic [ACC_W-1:0]  mac_res_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output mac_valid_o, mac_a_o, mac_b_o, mac_clr_o,
        input  mac_ready_i, mac_res_valid_i, mac_res_i
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  mac_valid_o, mac_a_o, mac_b_o, mac_clr_o,
        output mac_ready_i, mac_res_valid_i, mac_res_i
    );
endinterface

// File: rtl/fmac_wb_frontend.sv
// Wishbone-classic register front end for the F-MAC: queues operand pairs,
// issues them one at a time over valid/ready and captures accumulator results.
module fmac_wb_frontend #(
    parameter int          DATA_W     = 16,
    parameter int          ACC_W      = 32,
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    fmac_wb_frontend_if.slave bus,
    output logic              irq_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [7:0] OFS_OPERAND = 8'h00;
    localparam logic [7:0] OFS_CTRL    = 8'h04;
    localparam logic [7:0] OFS_STATUS  = 8'h08;
    localparam logic [7:0] OFS_RESULT  = 8'h0C;
    localparam logic [7:0] OFS_COUNT   = 8'h10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic              hit;
    logic              ack_q;
    logic              req_we_q;
    logic              req_sel0_q;
    logic [7:0]        req_ofs_q;
    logic [31:0]       req_dat_q;
    logic [31:0]       rd_data;

    logic              wr_strobe;
    logic              wr_operand;
    logic              wr_ctrl;
    logic              wr_status;

    logic [DATA_W-1:0] fifo_a [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_b [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic              clr_pend_q;
    logic              irq_en_q;
    logic              ovf_q;
    logic              done_q;
    logic              irq_q;
    logic [31:0]       result_q;
    logic [15:0]       count_q;
    logic [31:0]       res_fit;
    logic              capture;
    logic              busy;

    logic              mac_valid;
    logic              mac_clr;

    logic              unused_sel;
    assign unused_sel = ^bus.wbs_sel_i[3:1];

    assign hit = bus.wbs_cyc_i & bus.wbs_stb_i &
                 (bus.wbs_adr_i[31:8] == ADDR_BASE[31:8]);

    // The access is latched when it is accepted so its side effects land in
    // the ack cycle even if the master drops the bus as soon as it sees ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            req_we_q   <= 1'b0;
            req_sel0_q <= 1'b0;
            req_ofs_q  <= '0;
            req_dat_q  <= '0;
        end else begin
            ack_q <= hit & ~ack_q;
            if (hit && !ack_q) begin
                req_we_q   <= bus.wbs_we_i;
                req_sel0_q <= bus.wbs_sel_i[0];
                req_ofs_q  <= bus.wbs_adr_i[7:0];
                req_dat_q  <= bus.wbs_dat_i;
            end
        end
    end

    assign wr_strobe  = ack_q & req_we_q;
    assign wr_operand = wr_strobe & (req_ofs_q == OFS_OPERAND);
    assign wr_ctrl    = wr_strobe & req_sel0_q & (req_ofs_q == OFS_CTRL);
    assign wr_status  = wr_strobe & req_sel0_q & (req_ofs_q == OFS_STATUS);

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign push  = wr_operand & ~full;
    assign pop   = (state_q == ISSUE) & bus.mac_ready_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_a[i] <= '0;
                fifo_b[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_a[wr_ptr_q] <= req_dat_q[DATA_W-1:0];
                fifo_b[wr_ptr_q] <= req_dat_q[16 +: DATA_W];
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    if (ACC_W >= 32) begin : g_res_trunc
        assign res_fit = bus.mac_res_i[31:0];
    end else begin : g_res_ext
        assign res_fit = {{(32-ACC_W){1'b0}}, bus.mac_res_i};
    end

    assign capture = (state_q == WAIT) & bus.mac_res_valid_i;

    // Sticky flags: a hardware set in the same cycle as a software clear wins.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            clr_pend_q <= 1'b0;
            irq_en_q   <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
            result_q   <= '0;
            count_q    <= '0;
        end else begin
            if (wr_ctrl && req_dat_q[0]) begin
                clr_pend_q <= 1'b1;
            end else if (state_q == CLEAR) begin
                clr_pend_q <= 1'b0;
            end
            if (wr_ctrl) begin
                irq_en_q <= req_dat_q[1];
            end
            if (wr_operand && full) begin
                ovf_q <= 1'b1;
            end else if (wr_status && req_dat_q[3]) begin
                ovf_q <= 1'b0;
            end
            if (capture) begin
                done_q   <= 1'b1;
                result_q <= res_fit;
                count_q  <= count_q + 16'd1;
            end else if (wr_status && req_dat_q[4]) begin
                done_q <= 1'b0;
            end
            irq_q <= done_q & irq_en_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A pending clear is always serviced before any queued operand pair.
    always_comb begin
        state_d   = state_q;
        mac_valid = 1'b0;
        mac_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_pend_q) begin
                    state_d = CLEAR;
                end else if (!empty) begin
                    state_d = ISSUE;
                end
            end
            CLEAR: begin
                mac_clr = 1'b1;
                state_d = IDLE;
            end
            ISSUE: begin
                mac_valid = 1'b1;
                if (bus.mac_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mac_res_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE) | ~empty;

    always_comb begin
        rd_data = '0;
        if (ack_q && !req_we_q) begin
            case (req_ofs_q)
                OFS_CTRL:   rd_data = {30'd0, irq_en_q, clr_pend_q};
                OFS_STATUS: rd_data = {27'd0, done_q, ovf_q, empty, full, busy};
                OFS_RESULT: rd_data = result_q;
                OFS_COUNT:  rd_data = {16'd0, count_q};
                default:    rd_data = '0;
            endcase
        end
    end

    assign bus.wbs_ack_o   = ack_q;
    assign bus.wbs_dat_o   = rd_data;
    assign bus.mac_valid_o = mac_valid;
    assign bus.mac_clr_o   = mac_clr;
    assign bus.mac_a_o     = mac_valid ? fifo_a[rd_ptr_q] : '0;
    assign bus.mac_b_o     = mac_valid ? fifo_b[rd_ptr_q] : '0;
    assign irq_o           = irq_q;

endmodule

// File: tb/tb_fmac_wb_frontend.sv
// Randomised bench for fmac_wb_frontend: a MAC model answers the operand
// handshake and a scoreboard of pushed pairs predicts every register value.
module tb_fmac_wb_frontend;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_OPERAND = BASE + 32'h00;
    localparam logic [31:0] A_CTRL    = BASE + 32'h04;
    localparam logic [31:0] A_STATUS  = BASE + 32'h08;
    localparam logic [31:0] A_RESULT  = BASE + 32'h0C;
    localparam logic [31:0] A_COUNT   = BASE + 32'h10;

    logic clk;
    logic rst;
    logic irq;

    int checks   = 0;
    int failures = 0;

    fmac_wb_frontend_if #(.DATA_W(16), .ACC_W(32)) bus ();

    fmac_wb_frontend #(
        .DATA_W    (16),
        .ACC_W     (32),
        .ADDR_BASE (BASE),
        .FIFO_DEPTH(4)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus),
        .irq_o   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MAC model: result = running sum of products, delivered mac_lat cycles later.
    int          mac_lat = 2;
    int          mac_cnt;
    logic [31:0] mac_acc;
    logic [31:0] mac_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_acc             <= '0;
            mac_pend            <= '0;
            mac_cnt             <= 0;
            bus.mac_res_valid_i <= 1'b0;
            bus.mac_res_i       <= '0;
        end else begin
            bus.mac_res_valid_i <= 1'b0;
            if (bus.mac_clr_o) mac_acc <= '0;
            if (bus.mac_valid_o && bus.mac_ready_i) begin
                mac_acc  <= mac_acc + 32'(bus.mac_a_o) * 32'(bus.mac_b_o);
                mac_pend <= mac_acc + 32'(bus.mac_a_o) * 32'(bus.mac_b_o);
                mac_cnt  <= mac_lat;
            end else if (mac_cnt > 0) begin
                mac_cnt <= mac_cnt - 1;
                if (mac_cnt == 1) begin
                    bus.mac_res_valid_i <= 1'b1;
                    bus.mac_res_i       <= mac_pend;
                end
            end
        end
    end

    // Passive monitor of the MAC link.
    int          res_seen     = 0;
    int          clr_cycles   = 0;
    int          valid_cycles = 0;
    logic [15:0] iss_a [$];
    logic [15:0] iss_b [$];
    int          evt   [$];

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            if (bus.mac_valid_o) valid_cycles++;
            if (bus.mac_valid_o && bus.mac_ready_i) begin
                iss_a.push_back(bus.mac_a_o);
                iss_b.push_back(bus.mac_b_o);
                evt.push_back(0);
            end
            if (bus.mac_clr_o) begin
                clr_cycles++;
                evt.push_back(1);
            end
            if (bus.mac_res_valid_i) res_seen++;
        end
    end

    // Reference state: sum of products since the last clear and result count.
    logic [31:0] exp_acc   = '0;
    logic [15:0] exp_count = '0;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rdat, output int lat);
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        lat  = -1;
        rdat = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o === 1'b1) begin
                lat  = i;
                rdat = bus.wbs_dat_o;
                break;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (lat < 0) begin
            failures++;
            $display("[TB] FAIL wb_timeout: adr=%h no ack within 8 cycles, required ack", adr);
        end
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        int          l;
        wb_access(1'b1, adr, dat, 4'hF, d, l);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        int l;
        wb_access(1'b0, adr, 32'h0, 4'hF, dat, l);
    endtask

    task automatic wait_results(input int target, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk); #1;
            if (res_seen >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        int          l;
        rst = 1'b1;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
        bus.mac_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.mac_valid_o, bus.mac_clr_o, irq, bus.wbs_ack_o} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_outputs: valid/clr/irq/ack=%b required 0000",
                     {bus.mac_valid_o, bus.mac_clr_o, irq, bus.wbs_ack_o});
        end
        checks++;
        if (bus.wbs_dat_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_dat: got %h required 0", bus.wbs_dat_o);
        end
        rst = 1'b0;
        wb_access(1'b0, A_STATUS, 32'h0, 4'hF, d, l);
        checks++;
        if (l != 1) begin
            failures++;
            $display("[TB] FAIL ack_latency: got %0d cycles required 1", l);
        end
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("[TB] FAIL reset_status: got %h required 00000004", d);
        end
        wb_read(A_COUNT, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_count: got %h required 0", d);
        end
        wb_read(A_RESULT, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_result: got %h required 0", d);
        end
        exp_acc   = '0;
        exp_count = '0;
    endtask

    task automatic test_single;
        logic [31:0] d;
        bit          ok;
        int r0 = res_seen, v0 = valid_cycles, n0 = iss_a.size();
        bus.mac_ready_i = 1'b1;
        wb_write(A_OPERAND, 32'h0003_0002);
        wait_results(r0 + 1, 50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL single_timeout: results=%0d required %0d", res_seen - r0, 1);
        end
        exp_acc   = exp_acc + 32'd6;
        exp_count = exp_count + 16'd1;
        checks++;
        if (iss_a.size() != n0 + 1 || iss_a[n0] !== 16'd2 || iss_b[n0] !== 16'd3) begin
            failures++;
            $display("[TB] FAIL single_issue: issues=%0d required 1 (a=2 b=3)", iss_a.size() - n0);
        end
        checks++;
        if (valid_cycles - v0 != 1) begin
            failures++;
            $display("[TB] FAIL single_valid_width: got %0d cycles required 1", valid_cycles - v0);
        end
        wb_read(A_RESULT, d);
        checks++;
        if (d !== exp_acc) begin
            failures++;
            $display("[TB] FAIL single_result: got %h required %h", d, exp_acc);
        end
        wb_read(A_COUNT, d);
        checks++;
        if (d !== {16'd0, exp_count}) begin
            failures++;
            $display("[TB] FAIL single_count: got %h required %h", d, exp_count);
        end
        wb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h14) begin
            failures++;
            $display("[TB] FAIL single_status: got %h required 00000014", d);
        end
        wb_write(A_STATUS, 32'h10);
        wb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("[TB] FAIL single_w1c: got %h required 00000004", d);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        logic [15:0] pa [5];
        logic [15:0] pb [5];
        bit          ok;
        int r0 = res_seen, n0 = iss_a.size();
        bus.mac_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pa[i] = 16'($urandom);
            pb[i] = 16'($urandom);
            wb_write(A_OPERAND, {pb[i], pa[i]});
        end
        wb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0B) begin
            failures++;
            $display("[TB] FAIL ovf_status: got %h required 0000000b (busy full ovf)", d);
        end
        bus.mac_ready_i = 1'b1;
        wait_results(r0 + 4, 200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL ovf_timeout: results=%0d required 4", res_seen - r0);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (iss_a.size() != n0 + 4) begin
            failures++;
            $display("[TB] FAIL ovf_issue_count: got %0d required 4", iss_a.size() - n0);
        end
        for (int i = 0; i < 4; i++) begin
            exp_acc   = exp_acc + 32'(pa[i]) * 32'(pb[i]);
            exp_count = exp_count + 16'd1;
            checks++;
            if (iss_a.size() > n0 + i && (iss_a[n0+i] !== pa[i] || iss_b[n0+i] !== pb[i])) begin
                failures++;
                $display("[TB] FAIL ovf_issue_order[%0d]: got %h/%h required %h/%h",
                         i, iss_a[n0+i], iss_b[n0+i], pa[i], pb[i]);
            end
        end
        wb_read(A_RESULT, d);
        checks++;
        if (d !== exp_acc) begin
            failures++;
            $display("[TB] FAIL ovf_result: got %h required %h", d, exp_acc);
        end
        wb_read(A_COUNT, d);
        checks++;
        if (d !== {16'd0, exp_count}) begin
            failures++;
            $display("[TB] FAIL ovf_count: got %h required %h", d, exp_count);
        end
        wb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h1C) begin
            failures++;
            $display("[TB] FAIL ovf_status_after: got %h required 0000001c", d);
        end
        wb_write(A_STATUS, 32'h18);
        wb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("[TB] FAIL ovf_w1c: got %h required 00000004", d);
        end
    endtask

    task automatic test_clear;
        logic [31:0] d;
        logic [15:0] a1, b1, a2, b2;
        bit          ok;
        int r0 = res_seen, e0 = evt.size(), c0 = clr_cycles;
        a1 = 16'($urandom); b1 = 16'($urandom);
        a2 = 16'($urandom); b2 = 16'($urandom);
        mac_lat = 6;
        bus.mac_ready_i = 1'b0;
        wb_write(A_OPERAND, {b1, a1});
        wb_write(A_OPERAND, {b2, a2});
        repeat (2) @(posedge clk);
        #1;
        bus.mac_ready_i = 1'b1;
        wb_write(A_CTRL, 32'h1);
        wait_results(r0 + 2, 200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL clear_timeout: results=%0d required 2", res_seen - r0);
        end
        checks++;
        if (evt.size() != e0 + 3 || evt[e0] != 0 || evt[e0+1] != 1 || evt[e0+2] != 0) begin
            failures++;
            $display("[TB] FAIL clear_order: %0d events, required issue,clear,issue", evt.size() - e0);
        end
        checks++;
        if (clr_cycles - c0 != 1) begin
            failures++;
            $display("[TB] FAIL clear_width: got %0d cycles required 1", clr_cycles - c0);
        end
        exp_acc   = 32'(a2) * 32'(b2);
        exp_count = exp_count + 16'd2;
        wb_read(A_RESULT, d);
        checks++;
        if (d !== exp_acc) begin
            failures++;
            $display("[TB] FAIL clear_result: got %h required %h", d, exp_acc);
        end
        wb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL clear_ctrl_readback: got %h required 0", d);
        end
        wb_write(A_STATUS, 32'h10);
        mac_lat = 2;
    endtask

    task automatic test_irq;
        logic [31:0] d;
        logic [15:0] a, b;
        bit          found = 1'b0;
        logic        rv;
        a = 16'($urandom); b = 16'($urandom);
        bus.mac_ready_i = 1'b1;
        wb_write(A_CTRL, 32'h2);
        wb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h2) begin
            failures++;
            $display("[TB] FAIL irq_ctrl_readback: got %h required 00000002", d);
        end
        wb_write(A_OPERAND, {b, a});
        for (int i = 0; i < 50; i++) begin
            rv = bus.mac_res_valid_i;
            @(posedge clk); #1;
            if (rv === 1'b1) begin
                found = 1'b1;
                checks++;
                if (irq !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL irq_early: got %b in DONE cycle required 0", irq);
                end
                @(posedge clk); #1;
                checks++;
                if (irq !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL irq_rise: got %b one cycle after DONE required 1", irq);
                end
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL irq_timeout: no result strobe, required one");
        end
        exp_acc   = exp_acc + 32'(a) * 32'(b);
        exp_count = exp_count + 16'd1;
        wb_write(A_STATUS, 32'h10);
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL irq_clear: got %b required 0", irq);
        end
        wb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("[TB] FAIL irq_status_w1c: got %h required 00000004", d);
        end
        wb_write(A_CTRL, 32'h0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        int          acks = 0;
        int          bad_data = 0;
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = A_STATUS; bus.wbs_sel_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o === 1'b1) begin
                acks++;
                if (bus.wbs_dat_o !== 32'h4) bad_data++;
            end
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        checks++;
        if (acks != 3) begin
            failures++;
            $display("[TB] FAIL b2b_acks: got %0d acks in 6 cycles required 3", acks);
        end
        checks++;
        if (bad_data != 0) begin
            failures++;
            $display("[TB] FAIL b2b_data: %0d reads differed from 00000004, required 0", bad_data);
        end
        // Off-base write must never be acknowledged nor push anything.
        @(posedge clk); #1;
        acks = 0;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_adr_i = BASE + 32'h100; bus.wbs_dat_i = $urandom;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o === 1'b1) acks++;
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        checks++;
        if (acks != 0) begin
            failures++;
            $display("[TB] FAIL nohit_ack: got %0d acks required 0", acks);
        end
        wb_write(A_COUNT + 32'h4, $urandom);
        wb_read(A_COUNT + 32'h4, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL unmapped_read: got %h required 0", d);
        end
        wb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("[TB] FAIL nohit_status: got %h required 00000004", d);
        end
    endtask

    task automatic test_random;
        logic [31:0] d;
        logic [15:0] pa [3];
        logic [15:0] pb [3];
        bit          ok;
        for (int round = 0; round < 4; round++) begin
            int r0 = res_seen, n0 = iss_a.size();
            for (int i = 0; i < 3; i++) begin
                pa[i] = 16'($urandom);
                pb[i] = 16'($urandom);
                bus.mac_ready_i = 1'($urandom_range(0, 1));
                wb_write(A_OPERAND, {pb[i], pa[i]});
            end
            ok = 1'b0;
            for (int c = 0; c < 400; c++) begin
                @(posedge clk); #1;
                bus.mac_ready_i = 1'($urandom_range(0, 1));
                if (res_seen >= r0 + 3) begin
                    ok = 1'b1;
                    break;
                end
            end
            bus.mac_ready_i = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (!ok || iss_a.size() != n0 + 3) begin
                failures++;
                $display("[TB] FAIL rand_issues[%0d]: got %0d issues required 3", round, iss_a.size() - n0);
            end
            for (int i = 0; i < 3; i++) begin
                exp_acc   = exp_acc + 32'(pa[i]) * 32'(pb[i]);
                exp_count = exp_count + 16'd1;
                checks++;
                if (iss_a.size() > n0 + i && (iss_a[n0+i] !== pa[i] || iss_b[n0+i] !== pb[i])) begin
                    failures++;
                    $display("[TB] FAIL rand_order[%0d.%0d]: got %h/%h required %h/%h",
                             round, i, iss_a[n0+i], iss_b[n0+i], pa[i], pb[i]);
                end
            end
            wb_read(A_RESULT, d);
            checks++;
            if (d !== exp_acc) begin
                failures++;
                $display("[TB] FAIL rand_result[%0d]: got %h required %h", round, d, exp_acc);
            end
            wb_read(A_COUNT, d);
            checks++;
            if (d !== {16'd0, exp_count}) begin
                failures++;
                $display("[TB] FAIL rand_count[%0d]: got %h required %h", round, d, exp_count);
            end
            wb_write(A_STATUS, 32'h18);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        bus.mac_ready_i = 1'b0;
        wb_write(A_OPERAND, $urandom);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.mac_valid_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midrst_pre_valid: got %b required 1", bus.mac_valid_o);
        end
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = A_STATUS; bus.wbs_sel_i = 4'hF;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mac_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_valid: got %b required 0", bus.mac_valid_o);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.wbs_ack_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_ack: got %b required 0", bus.wbs_ack_o);
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        rst = 1'b0;
        exp_acc   = '0;
        exp_count = '0;
        wb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("[TB] FAIL midrst_status: got %h required 00000004", d);
        end
        wb_read(A_COUNT, d);
        checks++;
        if (d !== {16'd0, exp_count}) begin
            failures++;
            $display("[TB] FAIL midrst_count: got %h required %h", d, exp_count);
        end
    endtask

    initial begin
        $display("[TB] starting fmac_wb_frontend bench");
        test_reset;
        test_single;
        test_overflow;
        test_clear;
        test_irq;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fmac_wb_frontend.md
Name: fmac_wb_frontend

Overview:
- Wishbone-classic slave and operand sequencer that sits directly upstream of the F-MAC datapath inside mac_core.
- Buffers operand pairs written by the management SoC, issues them one at a time to the MAC over a valid/ready handshake, and captures accumulator results.
- Exposes control, status and result registers, plus an interrupt on result completion.

Parameters:
- DATA_W, 16, operand width; A and B are each packed into one 32-bit write word.
- ACC_W, 32, MAC result width; the RESULT register is zero-extended or truncated to 32 bits.
- ADDR_BASE, 32'h3000_0000, slave base address; bits [31:8] are decoded.
- FIFO_DEPTH, 4, operand FIFO entries; power of two, minimum 2.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- mac_valid_o  out  1  operand pair valid to MAC
- mac_ready_i  in  1  MAC accepts the pair
- mac_a_o  out  DATA_W  operand A
- mac_b_o  out  DATA_W  operand B
- mac_clr_o  out  1  one-cycle accumulator clear pulse
- mac_res_valid_i  in  1  result strobe from MAC
- mac_res_i  in  ACC_W  accumulator value
- irq_o  out  1  done interrupt

Behaviour:
- Reset: all outputs 0; FIFO empty; all registers 0; FSM in IDLE. Reset mid-transaction aborts the transfer with no ack; queued operands are lost.
- Decode: hit = cyc & stb & (adr[31:8] == ADDR_BASE[31:8]).
- Ack: registered. wbs_ack_o = 1 in the cycle after a hit, provided ack was 0; it stays high exactly 1 cycle, so back-to-back accesses take 2 cycles each. A non-hit never produces an ack.
- Register effects: write side-effects and read data are applied on the cycle ack is asserted. Unmapped offsets read 0 and ignore writes.
- 0x00 OPERAND (W): pushes {B = dat[31:16], A = dat[15:0]} (low DATA_W bits of each half). wbs_sel_i is ignored. A push while full is dropped and sets OVF. Reads return 0.
- 0x04 CTRL (R/W): bit0 CLR, write-1 sets clr_pend and reads back clr_pend. bit1 IRQ_EN. Written only when sel[0] = 1.
- 0x08 STATUS (R; W1C on bits 3–4 when sel[0] = 1):
  - bit0 BUSY = (state != IDLE) | !empty
  - bit1 FULL
  - bit2 EMPTY
  - bit3 OVF (sticky)
  - bit4 DONE (sticky)
- 0x0C RESULT (R): last captured mac_res_i.
- 0x10 COUNT (R): 16-bit count of captured results; wraps 0xFFFF -> 0. Cleared only by reset.
- FIFO:
  - Push and pop in the same cycle with 0 < level < DEPTH: both occur, level unchanged.
  - Push while full: dropped even if a pop occurs the same cycle.
  - Push while empty with a simultaneous pop is impossible, because pop requires ISSUE, which requires non-empty.
- FSM, states IDLE / CLEAR / ISSUE / WAIT:
  - IDLE: if clr_pend -> CLEAR; else if !empty -> ISSUE. CLR has priority over queued operands.
  - CLEAR: mac_clr_o = 1 for 1 cycle; clr_pend <= 0; -> IDLE.
  - ISSUE: mac_valid_o = 1, mac_a_o/mac_b_o = FIFO head, held stable until mac_ready_i. On valid & ready: pop -> WAIT.
  - WAIT: on mac_res_valid_i: RESULT <= mac_res_i, COUNT += 1, DONE <= 1 -> IDLE.
  - mac_res_valid_i in any other state is ignored.
- Same-cycle DONE set and W1C: set wins.
- irq_o: registered, equal to DONE & IRQ_EN; asserts 1 cycle after DONE sets.
- Issue-to-issue minimum: 3 cycles (ISSUE, WAIT, IDLE) with mac_ready_i = 1 and a 1-cycle result.

Test Plan:
- Reset -> STATUS reads 0x4 (EMPTY only); irq_o = 0; mac_valid_o = 0; ack arrives 1 cycle after stb.
- Write OPERAND 0x0003_0002 with a MAC model (ready = 1, result = acc + a*b, latency 2) -> mac_a_o = 2, mac_b_o = 3 for 1 cycle; RESULT = 6; COUNT = 1; STATUS = 0x14.
- Five OPERAND writes while mac_ready_i = 0 (DEPTH = 4) -> FULL = 1, OVF = 1; after releasing ready, exactly 4 issues occur and COUNT = 4.
- Queue 2 pairs, then write CTRL = 0x1 while in WAIT -> the next issue is preceded by a 1-cycle mac_clr_o; RESULT then reflects only the post-clear product.
- CTRL = 0x2, one operand -> irq_o rises 1 cycle after DONE; W1C STATUS 0x10 -> DONE = 0 and irq_o = 0 the next cycle.
- Assert wb_rst_i mid-ISSUE with mac_ready_i = 0 -> mac_valid_o drops immediately; FIFO empty; no ack for the access in flight.
